// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_flex slice.
package sync_fifo_pkg;

  // Bits needed to represent values 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store write data on an enabled write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO, any depth >= 2, standard or first-word-fall-through read.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         wr_en,
  output logic                         full,
  output logic                         almost_full,
  output logic                         overflow,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         underflow,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  valid;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  fetch;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  // Status decode and access acceptance.
  // In FWFT mode rd_ptr points past the word held in dout, so a fetch
  // (preload or refill) is what moves it, not the consumer's read.
  always_comb begin
    full         = (count == CW'(DEPTH));
    almost_full  = (count >= CW'(AF_THRESH));
    almost_empty = (count <= CW'(AE_THRESH));
    empty        = (FWFT != 0) ? !valid : (count == '0);
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
    if (FWFT != 0)
      fetch = (!valid && (count != '0)) || (rd_acc && (count >= CW'(2)));
    else
      fetch = rd_acc;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= bump(wr_ptr);
      if (fetch)  rd_ptr <= bump(rd_ptr);
    end
  end

  // Occupancy counter, head word included.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register and FWFT head-valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (fetch) dout <= rdata;
      if (FWFT != 0) begin
        if (fetch)       valid <= 1'b1;
        else if (rd_acc) valid <= 1'b0;
      end
    end
  end

  // Registered error pulses for rejected accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: two FIFO configurations driven by shared random stimulus.
module tb_sync_fifo_flex;

  localparam int NI = 2;
  localparam int A_DEPTH = 5;
  localparam int A_AF = 4;
  localparam int A_AE = 1;
  localparam int B_DEPTH = 16;
  localparam int B_AF = 14;
  localparam int B_AE = 2;
  localparam int DEP [NI] = '{A_DEPTH, B_DEPTH};
  localparam int AFT [NI] = '{A_AF, B_AF};
  localparam int AET [NI] = '{A_AE, B_AE};
  localparam int FW  [NI] = '{0, 1};

  typedef struct packed {
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic [7:0] dval;
  } status_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  logic [7:0] dout_a, dout_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;
  logic full_a, af_a, ovf_a, emp_a, ae_a, unf_a;
  logic full_b, af_b, ovf_b, emp_b, ae_b, unf_b;

  logic [7:0] dq [NI];
  logic [4:0] cq [NI];
  logic fq [NI], afq [NI], oq [NI], eq [NI], aeq [NI], uq [NI];

  int checks = 0;
  int errors = 0;

  logic [7:0] mq    [NI][$];
  logic [7:0] rdq   [NI][$];
  status_t    stq   [NI][$];
  bit         vis   [NI];
  logic [7:0] mdout [NI];

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .DATA_WIDTH(8), .DEPTH(A_DEPTH), .AF_THRESH(A_AF), .AE_THRESH(A_AE), .FWFT(0)
  ) dut_a (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .full(full_a),
    .almost_full(af_a), .overflow(ovf_a), .rd_en(rd_en), .dout(dout_a),
    .empty(emp_a), .almost_empty(ae_a), .underflow(unf_a), .count(cnt_a)
  );

  sync_fifo_flex #(
    .DATA_WIDTH(8), .DEPTH(B_DEPTH), .AF_THRESH(B_AF), .AE_THRESH(B_AE), .FWFT(1)
  ) dut_b (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .full(full_b),
    .almost_full(af_b), .overflow(ovf_b), .rd_en(rd_en), .dout(dout_b),
    .empty(emp_b), .almost_empty(ae_b), .underflow(unf_b), .count(cnt_b)
  );

  assign dq[0] = dout_a;        assign dq[1] = dout_b;
  assign cq[0] = {2'b00, cnt_a}; assign cq[1] = cnt_b;
  assign fq[0] = full_a;        assign fq[1] = full_b;
  assign afq[0] = af_a;         assign afq[1] = af_b;
  assign oq[0] = ovf_a;         assign oq[1] = ovf_b;
  assign eq[0] = emp_a;         assign eq[1] = emp_b;
  assign aeq[0] = ae_a;         assign aeq[1] = ae_b;
  assign uq[0] = unf_a;         assign uq[1] = unf_b;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words plus the visible head
  // word. Predicts the state after the coming edge from the driven inputs.
  task automatic model_step(input int i);
    status_t s;
    int      sz;
    bit      emp_now, wa, ra;
    s  = '0;
    sz = mq[i].size();
    emp_now = (FW[i] != 0) ? !vis[i] : (sz == 0);
    if (reset) begin
      mq[i].delete();
      vis[i]   = 1'b0;
      mdout[i] = 8'h00;
    end else begin
      wa    = wr_en && (sz != DEP[i]);
      ra    = rd_en && !emp_now;
      s.ovf = wr_en && (sz == DEP[i]);
      s.unf = rd_en && emp_now;
      if (FW[i] != 0) begin
        if (ra) begin
          if (sz >= 2) mdout[i] = mq[i][1];
          else         vis[i]   = 1'b0;
        end else if (!vis[i] && sz >= 1) begin
          vis[i]   = 1'b1;
          mdout[i] = mq[i][0];
        end
      end else if (ra) begin
        mdout[i] = mq[i][0];
      end
      if (ra) begin
        rdq[i].push_back(mq[i][0]);
        void'(mq[i].pop_front());
      end
      if (wa) mq[i].push_back(din);
    end
    s.cnt  = 5'(mq[i].size());
    s.emp  = (FW[i] != 0) ? !vis[i] : (mq[i].size() == 0);
    s.ful  = (mq[i].size() == DEP[i]);
    s.af   = (mq[i].size() >= AFT[i]);
    s.ae   = (mq[i].size() <= AET[i]);
    s.dval = mdout[i];
    stq[i].push_back(s);
  endtask

  task automatic cycle(input bit rst, input bit w, input bit r, input logic [7:0] d);
    @(negedge clk);
    reset = rst;
    wr_en = w;
    rd_en = r;
    din   = d;
    for (int i = 0; i < NI; i++) model_step(i);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: consumes read data on each DUT handshake and checks status.
  initial begin : monitor
    bit      hs [NI];
    status_t s;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        hs[i] = !reset && rd_en && !eq[i];
        if (FW[i] != 0 && hs[i]) begin
          e = (rdq[i].size() > 0) ? rdq[i].pop_front() : 8'hxx;
          chk("fwft_read_data", i, int'(dq[i]), int'(e));
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (FW[i] == 0 && hs[i]) begin
          e = (rdq[i].size() > 0) ? rdq[i].pop_front() : 8'hxx;
          chk("std_read_data", i, int'(dq[i]), int'(e));
        end
        if (stq[i].size() > 0) begin
          s = stq[i].pop_front();
          chk("count", i, int'(cq[i]), int'(s.cnt));
          chk("empty", i, int'(eq[i]), int'(s.emp));
          chk("full", i, int'(fq[i]), int'(s.ful));
          chk("almost_full", i, int'(afq[i]), int'(s.af));
          chk("almost_empty", i, int'(aeq[i]), int'(s.ae));
          chk("overflow", i, int'(oq[i]), int'(s.ovf));
          chk("underflow", i, int'(uq[i]), int'(s.unf));
          chk("dout", i, int'(dq[i]), int'(s.dval));
        end
      end
    end
  end

  localparam int PW [5] = '{85, 15, 50, 100, 60};
  localparam int PR [5] = '{15, 85, 50, 100, 40};

  // Stimulus: directed scenarios followed by biased random phases.
  initial begin : stimulus
    for (int i = 0; i < NI; i++) begin
      vis[i]   = 1'b0;
      mdout[i] = 8'h00;
    end
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;

    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);

    // Single word: FWFT latency, then one read empties.
    cycle(1'b0, 1'b1, 1'b0, 8'h3C);
    idle(3);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);

    // Fill past capacity (overflow on both sizes), then drain past empty.
    for (int k = 1; k <= 18; k++) cycle(1'b0, 1'b1, 1'b0, 8'(k));
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, 8'hA0 + 8'(k));
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // Simultaneous access on an empty FIFO.
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    idle(2);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // Write/read pairs across pointer wrap.
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h40 + 8'(k));
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
    end
    idle(2);
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b1, 8'h00);

    // Reset with seven words stored, then fresh data only.
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b1, 1'b0, 8'h70 + 8'(k));
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h99);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    idle(2);

    // Random phases with varying write/read bias and rare resets.
    for (int ph = 0; ph < 5; ph++) begin
      for (int k = 0; k < 120; k++) begin
        cycle($urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < PW[ph],
              $urandom_range(0, 99) < PR[ph],
              8'($urandom));
      end
    end

    idle(3);
    @(posedge clk);
    #3;
    for (int i = 0; i < NI; i++) begin
      chk("pending_reads", i, rdq[i].size(), 0);
      chk("pending_status", i, stq[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
